// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel-generation path
// (1280x1024 @ 1688x1066 total, 640x320 RGB565 background scaled x2).
package vga_pkg;

  // Timing generator geometry
  localparam int H_START  = 360;   // first active h_cnt (sync + back porch)
  localparam int V_START  = 41;    // first active v_cnt (sync + back porch)
  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 1024;
  localparam int COL      = 1688;  // total clocks per line
  localparam int ROW      = 1066;  // total lines per frame

  // Background image and scrolling
  localparam int IMG_W       = 640;
  localparam int IMG_H       = 320;
  localparam int SCROLL_STEP = 2;   // source pixels per unit of view
  localparam int PIPE_LAT    = 4;   // h_cnt/v_cnt sample to RGB/sync out

  // RGB565 field MSB positions; the top 4 bits of each field feed the 4:4:4 output
  localparam int R_MSB = 15;
  localparam int G_MSB = 10;
  localparam int B_MSB = 4;

  localparam logic [11:0] SKY_RGB   = 12'h69F;
  localparam logic [15:0] KEY_COLOR = 16'hF81F;

  // Per-pixel region flags carried down the pipeline
  typedef struct packed {
    logic active;  // inside the 1280x1024 window
    logic img;     // inside the scaled 1280x640 image band
  } pix_flags_t;

  // Truncate RGB565 to 4:4:4 by keeping the top nibble of each field
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
    return {px[R_MSB -: 4], px[G_MSB -: 4], px[B_MSB -: 4]};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to RESET_VAL.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // First tap captures the input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_reg[0] <= RESET_VAL;
    else      stage_reg[0] <= d;
  end

  // Remaining taps shift one position per clock
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_reg[gi] <= RESET_VAL;
        else      stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_bg_scroller.sv
// Background pixel generator: scaled x2, horizontally wrapping scroll of a
// 640x320 RGB565 ROM image, sky fill outside the image and on keyed pixels.
// Four-clock pipeline; hs/vs are delayed to stay aligned with the colour.
module vga_bg_scroller
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic [7:0]  view,
  output logic [17:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [3:0]  O_red,
  output logic [3:0]  O_green,
  output logic [3:0]  O_blue,
  output logic        hs,
  output logic        vs
);

  logic [7:0]  view_q;

  // Stage 0 (combinational decode of the raw counters)
  logic        active_now;
  logic        img_now;
  logic [9:0]  xs_now;   // source-image column before scrolling (x>>1)
  logic [8:0]  ys_now;   // source-image row (y>>1)

  // Stage 1
  logic [9:0]  xs_reg;
  logic [8:0]  ys_reg;
  pix_flags_t  flags1_reg;

  // Stage 2 (combinational address generation)
  logic [10:0] sx_raw;
  logic [9:0]  sx;
  logic [17:0] addr_next;
  logic [17:0] rom_addr_reg;

  // Stage 3 flags, aligned with rom_data
  pix_flags_t  flags3;

  // Stage 4
  logic [11:0] rgb_reg;

  // Scroll position only changes at frame start so a frame never tears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             view_q <= '0;
    else if (h_cnt == '0 && v_cnt == '0)  view_q <= view;
  end

  // Active-window decode; upper bounds are exclusive
  always_comb begin
    active_now = (h_cnt >= 12'(H_START)) && (h_cnt < 12'(H_START + H_ACTIVE)) &&
                 (v_cnt >= 12'(V_START)) && (v_cnt < 12'(V_START + V_ACTIVE));
    xs_now     = 10'((h_cnt - 12'(H_START)) >> 1);
    ys_now     = 9'((v_cnt - 12'(V_START)) >> 1);
    img_now    = active_now && (ys_now < 9'(IMG_H));
  end

  // Stage 1: register the scaled coordinates and region flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xs_reg     <= '0;
      ys_reg     <= '0;
      flags1_reg <= '0;
    end else begin
      xs_reg     <= xs_now;
      ys_reg     <= ys_now;
      flags1_reg <= '{active: active_now, img: img_now};
    end
  end

  // Scroll with wrap: max sx_raw is 639+510, so one conditional subtract suffices;
  // sy*640 is built from two shifts to avoid a multiplier
  always_comb begin
    sx_raw    = 11'(xs_reg) + 11'(view_q) * 11'(SCROLL_STEP);
    sx        = (sx_raw >= 11'(IMG_W)) ? 10'(sx_raw - 11'(IMG_W)) : 10'(sx_raw);
    addr_next = (18'(ys_reg) << 9) + (18'(ys_reg) << 7) + 18'(sx);
  end

  // Stage 2: ROM address register, held outside the image band
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                rom_addr_reg <= '0;
    else if (flags1_reg.img) rom_addr_reg <= addr_next;
  end

  assign rom_addr = rom_addr_reg;

  // Flags ride two more clocks to meet the ROM read data
  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (2),
    .RESET_VAL (2'b00)
  ) u_flag_dly (
    .clk (clk),
    .rst (rst),
    .d   (flags1_reg),
    .q   (flags3)
  );

  // Stage 4: colour select (blank, sky fill, keyed sky, or image pixel)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      rgb_reg <= '0;
    else if (!flags3.active)                       rgb_reg <= '0;
    else if (!flags3.img || rom_data == KEY_COLOR) rgb_reg <= SKY_RGB;
    else                                           rgb_reg <= rgb565_to_444(rom_data);
  end

  assign {O_red, O_green, O_blue} = rgb_reg;

  // Sync follows the full pipeline depth; idle level is high
  vga_delay_line #(
    .WIDTH     (2),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   ({hs_i, vs_i}),
    .q   ({hs, vs})
  );

endmodule
